// File: rtl/log_mult_dot_accum_pkg.sv
// Shared types and the saturation helper for the log-multiplier dot-product accumulator.
package log_mac_pkg;

  typedef enum logic {ACC, OUT} state_t;

  localparam int PROD_W = 16;
  localparam int SAT_W  = 33;  // enough headroom for any ACC_W + 1 up to 32

  typedef struct packed {
    logic                    clip;
    logic signed [SAT_W-1:0] val;
  } sat_res_t;

  function automatic sat_res_t sat_clip(input logic signed [SAT_W-1:0] value, input int width);
    logic signed [SAT_W-1:0] one, hi, lo;
    one = SAT_W'(1);
    hi  = (one <<< (width - 1)) - one;
    lo  = ~hi;
    sat_clip.clip = 1'b0;
    sat_clip.val  = value;
    if (value > hi) begin
      sat_clip.clip = 1'b1;
      sat_clip.val  = hi;
    end else if (value < lo) begin
      sat_clip.clip = 1'b1;
      sat_clip.val  = lo;
    end
  endfunction

endpackage

// File: rtl/log_mult_dot_accum_sat_adder.sv
// Combinational saturating add of a signed product onto a signed ACC_W-bit value.
module sat_adder
  import log_mac_pkg::*;
#(
  parameter int ACC_W = 20
) (
  input  logic signed [ACC_W-1:0]  a,
  input  logic signed [PROD_W-1:0] b,
  output logic signed [ACC_W-1:0]  sum,
  output logic                     clip
);

  logic [SAT_W-1:0] wide;
  sat_res_t         res;
  logic             unused_hi;

  always_comb begin
    wide = {{(SAT_W-ACC_W){a[ACC_W-1]}}, a} + {{(SAT_W-PROD_W){b[PROD_W-1]}}, b};
    res  = sat_clip(wide, ACC_W);
    sum  = res.val[ACC_W-1:0];
    clip = res.clip;
  end

  assign unused_hi = ^res.val[SAT_W-1:ACC_W];

endmodule

// File: rtl/log_mult_dot_accum.sv
// Accumulates VEC_LEN signed products into a saturated dot product with valid/ready output.
module log_mult_dot_accum
  import log_mac_pkg::*;
#(
  parameter int VEC_LEN = 8,
  parameter int ACC_W   = 20
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     clear,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [PROD_W-1:0] product,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [ACC_W-1:0]  acc_out,
  output logic                     sat_flag
);

  localparam int             CNT_W = 8;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  state_t                   state_q, state_d;
  logic [CNT_W-1:0]         count_q, count_d;
  logic signed [ACC_W-1:0]  acc_q, acc_d, acc_out_q, acc_out_d;
  logic                     out_valid_q, out_valid_d, sat_flag_q, sat_flag_d;
  logic                     sticky_q, sticky_d;
  logic signed [ACC_W-1:0]  add_a, sum;
  logic                     clip, accept, take, first, sticky_eff;

  // In OUT a product can only enter in the cycle the held result leaves.
  assign in_ready   = (state_q == ACC) | out_ready;
  assign accept     = in_valid & in_ready & ~clear;
  assign take       = out_valid_q & out_ready;
  assign first      = (count_q == '0);
  assign add_a      = first ? '0 : acc_q;
  assign sticky_eff = ~first & sticky_q;

  sat_adder #(.ACC_W(ACC_W)) u_add (
    .a    (add_a),
    .b    (product),
    .sum  (sum),
    .clip (clip)
  );

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    acc_d       = acc_q;
    acc_out_d   = acc_out_q;
    out_valid_d = out_valid_q;
    sat_flag_d  = sat_flag_q;
    sticky_d    = sticky_q;
    if (clear) begin
      state_d     = ACC;
      count_d     = '0;
      acc_d       = '0;
      sticky_d    = 1'b0;
      out_valid_d = 1'b0;
    end else if (accept) begin
      sticky_d = sticky_eff | clip;
      if (count_q == LAST) begin
        acc_out_d   = sum;
        sat_flag_d  = sticky_eff | clip;
        out_valid_d = 1'b1;
        count_d     = '0;
        state_d     = OUT;
      end else begin
        // Accepting while in OUT implies the result was taken this cycle.
        acc_d       = sum;
        count_d     = count_q + 1'b1;
        out_valid_d = 1'b0;
        state_d     = ACC;
      end
    end else if (take) begin
      out_valid_d = 1'b0;
      state_d     = ACC;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ACC;
      count_q     <= '0;
      acc_q       <= '0;
      acc_out_q   <= '0;
      out_valid_q <= 1'b0;
      sat_flag_q  <= 1'b0;
      sticky_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      acc_q       <= acc_d;
      acc_out_q   <= acc_out_d;
      out_valid_q <= out_valid_d;
      sat_flag_q  <= sat_flag_d;
      sticky_q    <= sticky_d;
    end
  end

  assign out_valid = out_valid_q;
  assign acc_out   = acc_out_q;
  assign sat_flag  = sat_flag_q;

endmodule
